// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of event counters with sticky overflow, snapshot shadows and indexed read port
module perf_counter_bank #(
  parameter int NUM_CNT  = 8,
  parameter int WIDTH    = 32,
  parameter int SATURATE = 0,
  parameter int IDX_W    = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CNT-1:0] inc,
  input  logic               freeze,
  input  logic               clr_all,
  input  logic               clr_en,
  input  logic [IDX_W-1:0]   clr_idx,
  input  logic               snap,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_idx,
  input  logic               rd_shadow,
  output logic               rd_valid,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_ovf,
  output logic               ovf_any
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0]   cnt        [NUM_CNT];
  logic [WIDTH-1:0]   shadow     [NUM_CNT];
  logic [NUM_CNT-1:0] ovf;
  logic [NUM_CNT-1:0] shadow_ovf;

  logic [WIDTH-1:0]   sel_data;
  logic               sel_ovf;

  // Live counters and shadows: rst > clr_all > channel clear > increment.
  // Shadows always capture the pre-update live values of the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr_all) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
      ovf        <= '0;
      shadow_ovf <= '0;
    end else begin
      if (snap) begin
        for (int i = 0; i < NUM_CNT; i++) begin
          shadow[i] <= cnt[i];
        end
        shadow_ovf <= ovf;
      end
      for (int i = 0; i < NUM_CNT; i++) begin
        // An out-of-range clr_idx never matches any channel, so it is ignored.
        if (clr_en && (clr_idx == IDX_W'(i))) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (inc[i] && !freeze) begin
          if (cnt[i] == ALL_ONES) begin
            ovf[i] <= 1'b1;
            cnt[i] <= (SATURATE != 0) ? ALL_ONES : '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Read mux; out-of-range indices fall through to zero.
  always_comb begin
    sel_data = '0;
    sel_ovf  = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        sel_data = rd_shadow ? shadow[i]     : cnt[i];
        sel_ovf  = rd_shadow ? shadow_ovf[i] : ovf[i];
      end
    end
  end

  // Registered read response; data holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_ovf   <= 1'b0;
    end else if (rd_en) begin
      rd_valid <= 1'b1;
      rd_data  <= sel_data;
      rd_ovf   <= sel_ovf;
    end else begin
      rd_valid <= 1'b0;
    end
  end

  // Overflow summary taken straight from the flag registers.
  always_comb begin
    ovf_any = |ovf;
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - directed self-checking bench for perf_counter_bank
module tb_perf_counter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] inc_a, inc_w, inc_s;
  logic       freeze, clr_all, clr_en, snap, rd_en, rd_shadow;
  logic [2:0] clr_idx, rd_idx;

  logic       rd_valid_a, rd_ovf_a, ovf_any_a;
  logic [7:0] rd_data_a;
  logic       rd_valid_w, rd_ovf_w, ovf_any_w;
  logic [3:0] rd_data_w;
  logic       rd_valid_s, rd_ovf_s, ovf_any_s;
  logic [3:0] rd_data_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CNT(6), .WIDTH(8), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .inc(inc_a), .freeze(freeze), .clr_all(clr_all),
    .clr_en(clr_en), .clr_idx(clr_idx), .snap(snap), .rd_en(rd_en),
    .rd_idx(rd_idx), .rd_shadow(rd_shadow), .rd_valid(rd_valid_a),
    .rd_data(rd_data_a), .rd_ovf(rd_ovf_a), .ovf_any(ovf_any_a)
  );

  perf_counter_bank #(.NUM_CNT(6), .WIDTH(4), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .inc(inc_w), .freeze(freeze), .clr_all(clr_all),
    .clr_en(clr_en), .clr_idx(clr_idx), .snap(snap), .rd_en(rd_en),
    .rd_idx(rd_idx), .rd_shadow(rd_shadow), .rd_valid(rd_valid_w),
    .rd_data(rd_data_w), .rd_ovf(rd_ovf_w), .ovf_any(ovf_any_w)
  );

  perf_counter_bank #(.NUM_CNT(6), .WIDTH(4), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .inc(inc_s), .freeze(freeze), .clr_all(clr_all),
    .clr_en(clr_en), .clr_idx(clr_idx), .snap(snap), .rd_en(rd_en),
    .rd_idx(rd_idx), .rd_shadow(rd_shadow), .rd_valid(rd_valid_s),
    .rd_data(rd_data_s), .rd_ovf(rd_ovf_s), .ovf_any(ovf_any_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_read(input logic [2:0] idx, input logic sh);
    rd_en     = 1'b1;
    rd_idx    = idx;
    rd_shadow = sh;
    tick();
    rd_en     = 1'b0;
  endtask

  task automatic run_inc(input logic [5:0] a, input logic [5:0] w, input logic [5:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      inc_a = a;
      inc_w = w;
      inc_s = s;
      tick();
    end
    inc_a = '0;
    inc_w = '0;
    inc_s = '0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    rd_en = 1'b1;
    run_inc(6'h3f, 6'h3f, 6'h3f, 2);
    rd_en = 1'b0;
    tests++;
    if (rd_valid_a !== 1'b0 || rd_data_a !== 8'd0 || rd_ovf_a !== 1'b0 || ovf_any_a !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b data=%0d ovf=%b any=%b expected 0 0 0 0",
               rd_valid_a, rd_data_a, rd_ovf_a, ovf_any_a);
    end
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      issue_read(3'(c), 1'b0);
      tests++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== 8'd0 || rd_ovf_a !== 1'b0) begin
        fails++;
        $display("FAIL reset_read ch%0d: got valid=%b data=%0d ovf=%b expected 1 0 0",
                 c, rd_valid_a, rd_data_a, rd_ovf_a);
      end
    end
    tick();
    run_inc(6'h01, 6'h00, 6'h00, 5);
    tests++;
    if (rd_valid_a !== 1'b0) begin
      fails++;
      $display("FAIL idle_valid: got %b expected 0", rd_valid_a);
    end
    issue_read(3'd0, 1'b0);
    tests++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 8'd5) begin
      fails++;
      $display("FAIL count5: got valid=%b data=%0d expected 1 5", rd_valid_a, rd_data_a);
    end
  endtask

  task automatic test_wrap();
    run_inc(6'h00, 6'h04, 6'h00, 15);
    issue_read(3'd2, 1'b0);
    tests++;
    if (rd_data_w !== 4'd15 || rd_ovf_w !== 1'b0 || ovf_any_w !== 1'b0) begin
      fails++;
      $display("FAIL wrap_at_max: got data=%0d ovf=%b any=%b expected 15 0 0", rd_data_w, rd_ovf_w, ovf_any_w);
    end
    run_inc(6'h00, 6'h04, 6'h00, 1);
    issue_read(3'd2, 1'b0);
    tests++;
    if (rd_data_w !== 4'd0 || rd_ovf_w !== 1'b1 || ovf_any_w !== 1'b1) begin
      fails++;
      $display("FAIL wrap_roll: got data=%0d ovf=%b any=%b expected 0 1 1", rd_data_w, rd_ovf_w, ovf_any_w);
    end
    run_inc(6'h00, 6'h04, 6'h00, 3);
    issue_read(3'd2, 1'b0);
    tests++;
    if (rd_data_w !== 4'd3 || rd_ovf_w !== 1'b1) begin
      fails++;
      $display("FAIL wrap_sticky: got data=%0d ovf=%b expected 3 1", rd_data_w, rd_ovf_w);
    end
  endtask

  task automatic test_saturate();
    run_inc(6'h00, 6'h00, 6'h02, 20);
    issue_read(3'd1, 1'b0);
    tests++;
    if (rd_data_s !== 4'd15 || rd_ovf_s !== 1'b1 || ovf_any_s !== 1'b1) begin
      fails++;
      $display("FAIL saturate: got data=%0d ovf=%b any=%b expected 15 1 1", rd_data_s, rd_ovf_s, ovf_any_s);
    end
    issue_read(3'd0, 1'b0);
    tests++;
    if (rd_data_s !== 4'd0 || rd_ovf_s !== 1'b0) begin
      fails++;
      $display("FAIL saturate_other: got data=%0d ovf=%b expected 0 0", rd_data_s, rd_ovf_s);
    end
  endtask

  task automatic test_clear();
    clr_all = 1'b1;
    tick();
    clr_all = 1'b0;
    run_inc(6'h18, 6'h00, 6'h00, 2);
    run_inc(6'h08, 6'h00, 6'h00, 5);
    inc_a   = 6'h18;
    clr_en  = 1'b1;
    clr_idx = 3'd3;
    tick();
    inc_a  = '0;
    clr_en = 1'b0;
    issue_read(3'd3, 1'b0);
    tests++;
    if (rd_data_a !== 8'd0 || rd_ovf_a !== 1'b0) begin
      fails++;
      $display("FAIL clr_vs_inc ch3: got data=%0d ovf=%b expected 0 0", rd_data_a, rd_ovf_a);
    end
    issue_read(3'd4, 1'b0);
    tests++;
    if (rd_data_a !== 8'd3) begin
      fails++;
      $display("FAIL clr_neighbour ch4: got %0d expected 3", rd_data_a);
    end
    run_inc(6'h00, 6'h04, 6'h02, 2);
    clr_all = 1'b1;
    run_inc(6'h3f, 6'h3f, 6'h3f, 1);
    clr_all = 1'b0;
    tests++;
    if (ovf_any_w !== 1'b0 || ovf_any_s !== 1'b0) begin
      fails++;
      $display("FAIL clr_all_ovf: got any_w=%b any_s=%b expected 0 0", ovf_any_w, ovf_any_s);
    end
    for (int c = 0; c < 6; c++) begin
      issue_read(3'(c), 1'b0);
      tests++;
      if (rd_data_a !== 8'd0 || rd_data_w !== 4'd0 || rd_data_s !== 4'd0) begin
        fails++;
        $display("FAIL clr_all ch%0d: got a=%0d w=%0d s=%0d expected 0 0 0", c, rd_data_a, rd_data_w, rd_data_s);
      end
    end
  endtask

  task automatic test_snapshot();
    run_inc(6'h03, 6'h00, 6'h00, 10);
    run_inc(6'h02, 6'h00, 6'h00, 10);
    snap      = 1'b1;
    inc_a     = 6'h03;
    rd_en     = 1'b1;
    rd_idx    = 3'd0;
    rd_shadow = 1'b0;
    tick();
    snap  = 1'b0;
    rd_en = 1'b0;
    inc_a = '0;
    tests++;
    if (rd_data_a !== 8'd10) begin
      fails++;
      $display("FAIL snap_cycle_read: got %0d expected 10", rd_data_a);
    end
    run_inc(6'h03, 6'h00, 6'h00, 4);
    issue_read(3'd0, 1'b1);
    tests++;
    if (rd_data_a !== 8'd10) begin
      fails++;
      $display("FAIL shadow ch0: got %0d expected 10", rd_data_a);
    end
    issue_read(3'd1, 1'b1);
    tests++;
    if (rd_data_a !== 8'd20) begin
      fails++;
      $display("FAIL shadow ch1: got %0d expected 20", rd_data_a);
    end
    issue_read(3'd0, 1'b0);
    tests++;
    if (rd_data_a !== 8'd15) begin
      fails++;
      $display("FAIL live ch0: got %0d expected 15", rd_data_a);
    end
    issue_read(3'd1, 1'b0);
    tests++;
    if (rd_data_a !== 8'd25) begin
      fails++;
      $display("FAIL live ch1: got %0d expected 25", rd_data_a);
    end
  endtask

  task automatic test_freeze_oor();
    freeze = 1'b1;
    run_inc(6'h3f, 6'h3f, 6'h3f, 8);
    freeze = 1'b0;
    issue_read(3'd0, 1'b0);
    tests++;
    if (rd_data_a !== 8'd15 || rd_data_w !== 4'd0) begin
      fails++;
      $display("FAIL freeze ch0: got a=%0d w=%0d expected 15 0", rd_data_a, rd_data_w);
    end
    issue_read(3'd2, 1'b0);
    tests++;
    if (rd_data_a !== 8'd0) begin
      fails++;
      $display("FAIL freeze ch2: got %0d expected 0", rd_data_a);
    end
    issue_read(3'd7, 1'b0);
    tests++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 8'd0 || rd_ovf_a !== 1'b0) begin
      fails++;
      $display("FAIL oor_read: got valid=%b data=%0d ovf=%b expected 1 0 0", rd_valid_a, rd_data_a, rd_ovf_a);
    end
    clr_en  = 1'b1;
    clr_idx = 3'd7;
    tick();
    clr_en = 1'b0;
    issue_read(3'd0, 1'b0);
    tests++;
    if (rd_data_a !== 8'd15) begin
      fails++;
      $display("FAIL oor_clear ch0: got %0d expected 15", rd_data_a);
    end
  endtask

  task automatic test_back_to_back();
    rd_en     = 1'b1;
    rd_idx    = 3'd1;
    rd_shadow = 1'b0;
    tick();
    tests++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 8'd25) begin
      fails++;
      $display("FAIL b2b_0: got valid=%b data=%0d expected 1 25", rd_valid_a, rd_data_a);
    end
    rd_idx    = 3'd1;
    rd_shadow = 1'b1;
    tick();
    tests++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 8'd20) begin
      fails++;
      $display("FAIL b2b_1: got valid=%b data=%0d expected 1 20", rd_valid_a, rd_data_a);
    end
    rd_idx    = 3'd0;
    rd_shadow = 1'b0;
    tick();
    tests++;
    if (rd_valid_a !== 1'b1 || rd_data_a !== 8'd15) begin
      fails++;
      $display("FAIL b2b_2: got valid=%b data=%0d expected 1 15", rd_valid_a, rd_data_a);
    end
    rd_en  = 1'b0;
    rd_idx = 3'd1;
    tick();
    tests++;
    if (rd_valid_a !== 1'b0 || rd_data_a !== 8'd15) begin
      fails++;
      $display("FAIL read_hold: got valid=%b data=%0d expected 0 15", rd_valid_a, rd_data_a);
    end
  endtask

  initial begin
    rst       = 1'b1;
    inc_a     = '0;
    inc_w     = '0;
    inc_s     = '0;
    freeze    = 1'b0;
    clr_all   = 1'b0;
    clr_en    = 1'b0;
    clr_idx   = '0;
    snap      = 1'b0;
    rd_en     = 1'b0;
    rd_idx    = '0;
    rd_shadow = 1'b0;
    test_reset();
    test_wrap();
    test_saturate();
    test_clear();
    test_snapshot();
    test_freeze_oor();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Bank of NUM_CNT independent event counters for CPU performance monitoring: stalls, cache misses, branch mispredicts, and similar events.
- Each channel provides:
  - a WIDTH-bit counter;
  - a sticky overflow flag;
  - optional saturating mode.
- Software/debug logic reads counters through a 1-cycle-latency indexed read port.
- An atomic snapshot captures all channels coherently into shadow registers.

Parameters:
- NUM_CNT, 8: number of counter channels (>=1).
- WIDTH, 32: counter width in bits (>=2).
- SATURATE, 0: 0 = counter wraps to 0 on overflow; 1 = counter holds at all-ones.
- IDX_W, $clog2(NUM_CNT) (min 1): width of index ports (derived).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- inc  in  NUM_CNT  per-channel increment request for this cycle.
- freeze  in  1  when 1, all inc are ignored; counters hold.
- clr_all  in  1  clears every counter, overflow flag and shadow register.
- clr_en  in  1  clears the single channel selected by clr_idx.
- clr_idx  in  IDX_W  channel to clear.
- snap  in  1  copies all live counters and overflow flags into shadow registers.
- rd_en  in  1  read request.
- rd_idx  in  IDX_W  channel to read.
- rd_shadow  in  1  0 = read the live counter; 1 = read the shadow copy.
- rd_valid  out  1  high the cycle after an accepted rd_en.
- rd_data  out  WIDTH  counter value returned for the read.
- rd_ovf  out  1  overflow flag (live or shadow) returned for the read.
- ovf_any  out  1  OR of all live overflow flags.

Behaviour:
- Reset (rst=1 at posedge): the following all go to 0 and are held while rst is high; rst overrides every other input.
  - all counters, overflow flags, shadow counters and shadow flags;
  - rd_valid, rd_data, rd_ovf, ovf_any.
- Counting, per channel i, each cycle with inc[i]=1 and freeze=0:
  - counter < all-ones: counter <= counter+1.
  - counter == all-ones and SATURATE=0: counter <= 0 and ovf[i] <= 1.
  - counter == all-ones and SATURATE=1: counter holds all-ones and ovf[i] <= 1.
  - The overflow flag sets only on an increment at all-ones. Merely reaching all-ones does not set it.
  - ovf[i] is sticky until channel clear, clr_all or rst.
- Increment granularity: at most +1 per channel per cycle; channels are fully independent.
- Clear priority, highest first: rst > clr_all > channel clear > increment.
  - clr_en with inc[clr_idx]=1 in the same cycle: that counter becomes 0, not 1, and its ovf becomes 0.
  - Other channels count normally in that cycle.
  - clr_idx >= NUM_CNT: the clear is ignored.
- Snapshot:
  - On snap=1, for every channel: shadow[i] <= pre-update counter value of that cycle, and shadow_ovf[i] <= pre-update ovf.
  - Increments or clears in the same cycle affect only the live values.
  - clr_all with snap in the same cycle: clr_all wins, so shadows become 0.
  - Shadows hold until the next snap, clr_all or rst.
- Read:
  - rd_en=1 at edge N: at edge N+1, rd_valid=1 and rd_data/rd_ovf present the value selected by rd_shadow and rd_idx, sampled before any cycle-N update.
  - Example: reading a channel while it increments returns the old value.
  - rd_en=0: rd_valid=0, and rd_data/rd_ovf hold their last value.
  - rd_idx >= NUM_CNT: rd_valid=1, rd_data=0, rd_ovf=0.
  - Back-to-back reads are supported: one result per cycle, no stall.
- ovf_any: registered OR of the live ovf flags. It reflects flag state after the current edge with no additional latency (combinational from the ovf registers).
- freeze: blocks increments only. Clears, snapshots and reads operate normally.

Test Plan:
- Reset and idle: assert rst for 2 cycles with inc all 1s, then release. Expect all reads return 0, rd_ovf=0, ovf_any=0. 5 cycles of inc[0]=1 followed by a read of channel 0 return 5, arriving one cycle after rd_en.
- Wrap, WIDTH=4, SATURATE=0: 15 increments on channel 2 followed by a read give 15 with ovf=0. One more increment gives 0 with ovf=1 and ovf_any=1. A further 3 increments give 3 with ovf still 1.
- Saturate, WIDTH=4, SATURATE=1: 20 increments on channel 1 give rd_data=15 and rd_ovf=1. Other channels are unaffected.
- Clear versus increment: channel 3 at 7; in the same cycle drive inc[3]=1, clr_en=1, clr_idx=3 and inc[4]=1, with channel 4 at 2. Expect channel 3 reads 0 and channel 4 reads 3. Then clr_all with inc all 1s leaves every channel at 0.
- Snapshot coherence: channels 0 and 1 at 10 and 20; pulse snap together with inc[0]=inc[1]=1, then 4 more increments. Expect shadow reads of 10 and 20 and live reads of 15 and 25. A read of channel 0 issued in the snap cycle returns live 10.
- Freeze and out-of-range: with freeze=1 and inc all 1s for 8 cycles, counts are unchanged. With NUM_CNT=6, rd_idx=7 gives rd_valid=1 and rd_data=0. clr_idx=7 changes nothing.
